afe_sample_ringbuf: RTL and testbench
=====================================

# afe_sample_ringbuf

Single-port-SRAM sample FIFO for the AFE readout path, replacing the fixed write/read-address buffer with a self-addressed circular buffer. It accepts channel-tagged ADC samples on a valid/ready write port, stores them in one `sram_wrapper_32b` instance, and returns them in order on a valid/ready read port towards the uDMA/bus side. It tracks occupancy, arbitrates the single SRAM port between writes and read prefetches, and supports a synchronous flush.

## Interface
- `DATA_WIDTH`, 24: sample bits stored per word.
- `CH_WIDTH`, 2: channel-tag bits stored beside the sample. `DATA_WIDTH+CH_WIDTH` ≤ 32 is required.
- `ADDR_WIDTH`, 10: SRAM address bits. Depth is `2**ADDR_WIDTH`.
- `clk_i` in 1: the only clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `clr_i` in 1: synchronous flush.
- `wr_valid_i` in 1: write request.
- `wr_ready_o` out 1: write accepted when this and `wr_valid_i` are both high.
- `wr_data_i` in `DATA_WIDTH`: sample.
- `wr_ch_i` in `CH_WIDTH`: channel tag.
- `rd_valid_o` out 1: output word valid.
- `rd_ready_i` in 1: consumer accepts the word.
- `rd_data_o` out `DATA_WIDTH`: sample out.
- `rd_ch_o` out `CH_WIDTH`: tag out.
- `fill_o` out `ADDR_WIDTH+1`: occupancy.
- `thr_i` in `ADDR_WIDTH+1`: watermark threshold. Present only with the macro.
- `wm_irq_o` out 1: watermark pulse. Present only with the macro.

## Operation
- **SRAM word layout:** `{zeros, ch, data}`.
  - `bwe_ni` is low for the low `DATA_WIDTH+CH_WIDTH` bits and high for the rest.
  - `ce_ni` is low only on a granted access.
  - `we_ni` is low only on a write.
- **Pointers:** `wptr` and `fptr` (fetch pointer), each `ADDR_WIDTH` bits, wrapping modulo depth.
- **`fill_o` (occupancy):** counts words accepted but not yet popped at the read port. This includes in-flight fetches and the output stage. It is incremented on write accept and decremented on a read pop (`rd_valid_o & rd_ready_i`). When both happen in the same cycle it is unchanged.
- **Unfetched count:** words written but not yet fetched.
- **Output stage:** a 2-entry register FIFO.
- **Fetch-eligible condition:**
  - unfetched > 0, and
  - (out-stage count + in-flight) − pop < 2.
- **Write-eligible condition:** `wr_valid_i` and `fill_o` < depth.
- **Arbitration (one SRAM access per cycle):**
  - If only one side is eligible, it is granted.
  - On a conflict, the `prio` bit decides, and `prio` toggles after each conflict.
  - Reset value of `prio` favours the write.
- **`wr_ready_o`:** `(fill_o` < depth`) & !clr_i & !(fetch granted)`.
- **Fetch data path:** a fetch granted in cycle N presents SRAM data in N+1. That data is pushed into the out stage at the end of N+1.
- **Read port:** `rd_valid_o` is high when the out stage is not empty, and it shows the head entry. Data holds stable while `rd_valid_o & !rd_ready_i`.
- **Full:** `fill_o` = depth. `wr_ready_o` is 0 and writes are never dropped or overwritten.
- **Empty:** `rd_valid_o` is 0, and no fetch is issued.
- **`clr_i` (flush):**
  - Highest priority.
  - No SRAM access in that cycle.
  - At the next edge, pointers, counts, `prio` and the out stage are zeroed.
  - An in-flight fetch result is discarded.
  - SRAM contents are untouched.
- **Reset (all outputs):** `rd_valid_o` 0, `rd_data_o` 0, `rd_ch_o` 0, `fill_o` 0, `wm_irq_o` 0, `wr_ready_o` 1 (combinational from the empty state).

## Timing
- Write accepted at edge N is visible in `fill_o` after edge N.
- Minimum latency from write to output, on an empty buffer with `rd_ready_i` high:
  - write in cycle N,
  - fetch in N+1,
  - `rd_valid_o` in N+3.
- Sustained throughput with only reads pending is 1 word/cycle.
- Under simultaneous write and read traffic, each side gets at least 1 access per 2 cycles.
- No same-cycle write-to-fetch bypass exists. A word written in cycle N is first fetch-eligible in N+1.
- Wrap-around is handled by modulo pointers. `fill_o` uses `ADDR_WIDTH+1` bits to distinguish full (depth) from empty (0).

## Configuration
- **Macro:** `AFE_RINGBUF_WATERMARK_EN`.
- **When defined:**
  - `thr_i` and `wm_irq_o` exist.
  - `wm_irq_o` is a registered single-cycle pulse, asserted the cycle after `fill_o` transitions from < `thr_i` to ≥ `thr_i`.
  - `thr_i` = 0 disables it.
  - Flush and reset clear the pending edge state.
- **When undefined:** both ports and all related logic are absent. Behaviour is otherwise identical.

## Test plan
- **Single word:** after reset, write 0xABCDEF with ch 2 in cycle 0, `rd_ready_i`=1 → `rd_valid_o` in cycle 3 with 0xABCDEF, ch 2. `fill_o` returns 0 after the pop.
- **Fill and drain:** `ADDR_WIDTH`=3. Write 8 words with `rd_ready_i`=0 → `fill_o`=8, `wr_ready_o`=0, and a 9th write is held. Drain all 8 → in-order data and `rd_valid_o`=0 at the end.
- **Contention:** continuous `wr_valid_i` and `rd_ready_i` with the buffer half full → grants alternate write/fetch, and no data is lost or reordered over 64 words across a pointer wrap.
- **Backpressure:** toggle `rd_ready_i` randomly → `rd_data_o` is held while stalled, and the sequence matches the scoreboard.
- **Flush:** with 5 words stored and a fetch in flight, pulse `clr_i` → next cycle `fill_o`=0 and `rd_valid_o`=0. A new write of 0x11 is the next word read.
- **Watermark (macro on):** `thr_i`=4. The 4th accepted write → exactly one `wm_irq_o` pulse. Draining to 3 and refilling to 4 → a second pulse.

Source files
------------

// File: rtl/afe_sample_ringbuf.sv
// afe_sample_ringbuf: self-addressed circular sample FIFO on one single-port SRAM.
// Channel-tagged ADC samples enter through a valid/ready write port, are stored
// as {zeros, ch, data} words, and are prefetched into a 2-entry output stage
// that drives the valid/ready read port. Writes and prefetches share the SRAM
// port through a toggling-priority arbiter; clr_i flushes all bookkeeping.
// Optional watermark pulse: define AFE_RINGBUF_WATERMARK_EN to add thr_i/wm_irq_o.
// DATA_WIDTH + CH_WIDTH must not exceed 32.

// Behavioural 32-bit single-port SRAM: active-low enables, per-bit write mask,
// read data registered one cycle after a granted read.
module sram_wrapper_32b #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  ce_ni,
  input  logic                  we_ni,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [31:0]           bwe_ni,
  output logic [31:0]           rdata_o
);
  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  // Masked write or registered read on each enabled cycle.
  always_ff @(posedge clk_i) begin
    if (!ce_ni) begin
      if (!we_ni) begin
        mem_q[addr_i] <= (mem_q[addr_i] & bwe_ni) | (wdata_i & ~bwe_ni);
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;
endmodule

module afe_sample_ringbuf #(
  parameter int DATA_WIDTH = 24,
  parameter int CH_WIDTH   = 2,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [CH_WIDTH-1:0]   wr_ch_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [CH_WIDTH-1:0]   rd_ch_o,
  output logic [ADDR_WIDTH:0]   fill_o
`ifdef AFE_RINGBUF_WATERMARK_EN
  ,
  input  logic [ADDR_WIDTH:0]   thr_i,
  output logic                  wm_irq_o
`endif
);
  localparam int SW = DATA_WIDTH + CH_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Bookkeeping registers and their next-state values.
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, fptr_q, fptr_d;
  logic [ADDR_WIDTH:0]   fill_q, fill_d, unf_q, unf_d;
  logic                  inflight_q, inflight_d;
  logic                  prio_q, prio_d;
  logic [1:0]            ocnt_q, ocnt_d;
  logic [SW-1:0]         ent0_q, ent0_d, ent1_q, ent1_d;

  // Arbitration and datapath signals.
  logic                  wr_elig_s, fetch_elig_s, wr_gnt_s, fetch_gnt_s, pop_s;
  logic [2:0]            occ_s;
  logic [1:0]            ocnt_after_s;
  logic [31:0]           sram_wdata_s, sram_bwe_s, sram_rdata_s;
  logic                  sram_ce_n_s, sram_we_n_s;
  logic [ADDR_WIDTH-1:0] sram_addr_s;
  logic                  unused_rdata_s;

  assign pop_s        = (ocnt_q != 2'd0) & rd_ready_i;
  // Out-stage slots already claimed (held + in flight) once this cycle's pop leaves.
  assign occ_s        = {1'b0, ocnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign ocnt_after_s = ocnt_q - {1'b0, pop_s};
  assign wr_elig_s    = wr_valid_i & (fill_q < DEPTH_C);
  assign fetch_elig_s = (unf_q != '0) & (occ_s < 3'd2);

  // Single-port arbiter: flush blocks everything, conflicts follow and flip prio.
  always_comb begin
    wr_gnt_s    = 1'b0;
    fetch_gnt_s = 1'b0;
    prio_d      = prio_q;
    if (clr_i) begin
      prio_d = 1'b0;
    end else if (wr_elig_s & fetch_elig_s) begin
      if (prio_q) begin
        fetch_gnt_s = 1'b1;
      end else begin
        wr_gnt_s = 1'b1;
      end
      prio_d = ~prio_q;
    end else if (wr_elig_s) begin
      wr_gnt_s = 1'b1;
    end else if (fetch_elig_s) begin
      fetch_gnt_s = 1'b1;
    end else begin
      prio_d = prio_q;
    end
  end

  assign wr_ready_o = (fill_q < DEPTH_C) & ~clr_i & ~fetch_gnt_s;

  // SRAM request: write uses wptr, prefetch uses fptr; only payload bits written.
  always_comb begin
    sram_wdata_s               = '0;
    sram_wdata_s[SW-1:0]       = {wr_ch_i, wr_data_i};
    sram_bwe_s                 = '1;
    sram_bwe_s[SW-1:0]         = '0;
    sram_ce_n_s                = ~(wr_gnt_s | fetch_gnt_s);
    sram_we_n_s                = ~wr_gnt_s;
    if (wr_gnt_s) begin
      sram_addr_s = wptr_q;
    end else begin
      sram_addr_s = fptr_q;
    end
  end

  sram_wrapper_32b #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sram (
    .clk_i   (clk_i),
    .ce_ni   (sram_ce_n_s),
    .we_ni   (sram_we_n_s),
    .addr_i  (sram_addr_s),
    .wdata_i (sram_wdata_s),
    .bwe_ni  (sram_bwe_s),
    .rdata_o (sram_rdata_s)
  );

  // Upper SRAM bits are always zero padding and carry no information.
  assign unused_rdata_s = ^sram_rdata_s;

  // Next-state for pointers, counters and the 2-entry output stage; flush zeroes all.
  always_comb begin
    wptr_d     = wptr_q;
    fptr_d     = fptr_q;
    fill_d     = fill_q;
    unf_d      = unf_q;
    inflight_d = fetch_gnt_s;
    ocnt_d     = ocnt_after_s;
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;

    if (wr_gnt_s) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (fetch_gnt_s) begin
      fptr_d = fptr_q + PTR_ONE;
    end else begin
      fptr_d = fptr_q;
    end

    case ({wr_gnt_s, pop_s})
      2'b10:   fill_d = fill_q + CNT_ONE;
      2'b01:   fill_d = fill_q - CNT_ONE;
      default: fill_d = fill_q;
    endcase

    case ({wr_gnt_s, fetch_gnt_s})
      2'b10:   unf_d = unf_q + CNT_ONE;
      2'b01:   unf_d = unf_q - CNT_ONE;
      default: unf_d = unf_q;
    endcase

    // Pop shifts the tail to the head; the vacated tail is cleared.
    if (pop_s) begin
      ent0_d = ent1_q;
      ent1_d = '0;
    end else begin
      ent0_d = ent0_q;
    end

    // Fetched word lands one cycle after its grant, into the first free slot.
    if (inflight_q) begin
      if (ocnt_after_s == 2'd0) begin
        ent0_d = sram_rdata_s[SW-1:0];
      end else begin
        ent1_d = sram_rdata_s[SW-1:0];
      end
      ocnt_d = ocnt_after_s + 2'd1;
    end else begin
      ocnt_d = ocnt_after_s;
    end

    if (clr_i) begin
      wptr_d     = '0;
      fptr_d     = '0;
      fill_d     = '0;
      unf_d      = '0;
      inflight_d = 1'b0;
      ocnt_d     = 2'd0;
      ent0_d     = '0;
      ent1_d     = '0;
    end else begin
      inflight_d = fetch_gnt_s;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q     <= '0;
      fptr_q     <= '0;
      fill_q     <= '0;
      unf_q      <= '0;
      inflight_q <= 1'b0;
      prio_q     <= 1'b0;
      ocnt_q     <= 2'd0;
      ent0_q     <= '0;
      ent1_q     <= '0;
    end else begin
      wptr_q     <= wptr_d;
      fptr_q     <= fptr_d;
      fill_q     <= fill_d;
      unf_q      <= unf_d;
      inflight_q <= inflight_d;
      prio_q     <= prio_d;
      ocnt_q     <= ocnt_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
    end
  end

  assign rd_valid_o = (ocnt_q != 2'd0);
  assign rd_data_o  = ent0_q[DATA_WIDTH-1:0];
  assign rd_ch_o    = ent0_q[SW-1:DATA_WIDTH];
  assign fill_o     = fill_q;

`ifdef AFE_RINGBUF_WATERMARK_EN
  logic above_q, above_d, wm_q, wm_d;

  // Rising-crossing detector on fill against the threshold; thr 0 disables it.
  always_comb begin
    above_d = (thr_i != '0) & (fill_q >= thr_i);
    wm_d    = above_d & ~above_q;
    if (clr_i) begin
      above_d = 1'b0;
      wm_d    = 1'b0;
    end else begin
      above_d = (thr_i != '0) & (fill_q >= thr_i);
    end
  end

  // Watermark edge state and registered pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      above_q <= 1'b0;
      wm_q    <= 1'b0;
    end else begin
      above_q <= above_d;
      wm_q    <= wm_d;
    end
  end

  assign wm_irq_o = wm_q;
`endif
endmodule

// File: tb/tb_afe_sample_ringbuf.sv
// Directed bench for afe_sample_ringbuf (ADDR_WIDTH=3, depth 8): a cycle vector
// table for the single-word path, then scoreboarded sequences for fill/drain,
// contention across wrap, backpressure, flush and (macro on) watermark.
module tb_afe_sample_ringbuf;
  localparam int AW = 3;
  localparam int DW = 24;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni, clr_i, wr_valid_i, wr_ready_o, rd_valid_o, rd_ready_i;
  logic [DW-1:0] wr_data_i, rd_data_o;
  logic [CW-1:0] wr_ch_i, rd_ch_o;
  logic [AW:0]   fill_o;
`ifdef AFE_RINGBUF_WATERMARK_EN
  logic [AW:0]   thr_i;
  logic          wm_irq_o;
`endif

  afe_sample_ringbuf #(.DATA_WIDTH(DW), .CH_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .wr_data_i  (wr_data_i),
    .wr_ch_i    (wr_ch_i),
    .rd_valid_o (rd_valid_o),
    .rd_ready_i (rd_ready_i),
    .rd_data_o  (rd_data_o),
    .rd_ch_o    (rd_ch_o),
    .fill_o     (fill_o)
`ifdef AFE_RINGBUF_WATERMARK_EN
    ,
    .thr_i      (thr_i),
    .wm_irq_o   (wm_irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic          wv;
    logic [DW-1:0] wd;
    logic [CW-1:0] wc;
    logic          rr;
    logic          clr;
    logic          e_wrdy;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic [CW-1:0] e_ch;
    logic [AW:0]   e_fill;
  } vec_t;

  vec_t vecs [7];

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  int wm_cnt = 0;
  logic [DW+CW-1:0] sb [$];
  bit               stall_chk  = 1'b0;
  logic [DW+CW-1:0] stall_data = '0;
  bit               last_acc   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sample handshakes now (away from the edge), update scoreboard, go to next negedge.
  task automatic cyc();
    logic [DW+CW-1:0] exp_w;
    last_acc = wr_valid_i && wr_ready_o;
    if (last_acc) sb.push_back({wr_ch_i, wr_data_i});
    if (stall_chk) begin
      chk("hold_valid", {31'd0, rd_valid_o}, 32'd1);
      chk("hold_data", {6'd0, rd_ch_o, rd_data_o}, {6'd0, stall_data});
    end
    if (rd_valid_o && rd_ready_i) begin
      pops++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", {rd_ch_o, rd_data_o});
      end else begin
        exp_w = sb.pop_front();
        chk("pop_data", {6'd0, rd_ch_o, rd_data_o}, {6'd0, exp_w});
      end
    end
    stall_chk  = rd_valid_o && !rd_ready_i;
    stall_data = {rd_ch_o, rd_data_o};
    if (clr_i) begin
      sb.delete();
      stall_chk = 1'b0;
    end
`ifdef AFE_RINGBUF_WATERMARK_EN
    if (wm_irq_o) wm_cnt++;
`endif
    @(negedge clk_i);
  endtask

  task automatic step();
    #1;
    cyc();
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [CW-1:0] c);
    bit done = 1'b0;
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wr_ch_i    = c;
    for (int k = 0; k < 40 && !done; k++) begin
      step();
      done = last_acc;
    end
    wr_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=not_accepted required=accepted data=%0h", d);
    end
  endtask

  task automatic drain(input int max_cyc);
    rd_ready_i = 1'b1;
    for (int k = 0; k < max_cyc && sb.size() != 0; k++) step();
    chk("drain_left", sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int miss;
    int viol;
    bit fullnow;

    //           wv    wd            wc    rr    clr   wrdy  rv    rd            ch    fill
    vecs[0] = '{1'b1, 24'hABCDEF, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 4'd0};
    vecs[1] = '{1'b0, 24'h000000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 2'd0, 4'd1};
    vecs[2] = '{1'b0, 24'h000000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 4'd1};
    vecs[3] = '{1'b0, 24'h000000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 24'hABCDEF, 2'd2, 4'd1};
    vecs[4] = '{1'b0, 24'h000000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 4'd0};
    vecs[5] = '{1'b1, 24'h123456, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000, 2'd0, 4'd0};
    vecs[6] = '{1'b0, 24'h000000, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h000000, 2'd0, 4'd0};

    rst_ni = 1'b0; clr_i = 1'b0; wr_valid_i = 1'b0; wr_data_i = '0; wr_ch_i = '0;
    rd_ready_i = 1'b0;
`ifdef AFE_RINGBUF_WATERMARK_EN
    thr_i = '0;
`endif
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("rst_rd_data", {8'd0, rd_data_o}, 32'd0);
    chk("rst_rd_ch", {30'd0, rd_ch_o}, 32'd0);
    chk("rst_fill", {28'd0, fill_o}, 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready_o}, 32'd1);
`ifdef AFE_RINGBUF_WATERMARK_EN
    chk("rst_wm_irq", {31'd0, wm_irq_o}, 32'd0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single word through the pipe, then a write blocked by flush.
    for (int i = 0; i < 7; i++) begin
      wr_valid_i = vecs[i].wv;
      wr_data_i  = vecs[i].wd;
      wr_ch_i    = vecs[i].wc;
      rd_ready_i = vecs[i].rr;
      clr_i      = vecs[i].clr;
      #1;
      chk($sformatf("vec%0d_wr_ready", i), {31'd0, wr_ready_o}, {31'd0, vecs[i].e_wrdy});
      chk($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid_o}, {31'd0, vecs[i].e_rv});
      chk($sformatf("vec%0d_fill", i), {28'd0, fill_o}, {28'd0, vecs[i].e_fill});
      if (vecs[i].e_rv) begin
        chk($sformatf("vec%0d_rd_data", i), {8'd0, rd_data_o}, {8'd0, vecs[i].e_rd});
        chk($sformatf("vec%0d_rd_ch", i), {30'd0, rd_ch_o}, {30'd0, vecs[i].e_ch});
      end
      @(negedge clk_i);
    end
    wr_valid_i = 1'b0; clr_i = 1'b0; rd_ready_i = 1'b0;

    // Fill to depth with the reader stalled, hold a 9th write, then drain.
    pops = 0;
    for (int i = 0; i < 8; i++) push_word(24'h100000 + 24'(i), 2'(i));
    wr_valid_i = 1'b1; wr_data_i = 24'hDEAD09; wr_ch_i = 2'd3;
    repeat (4) begin
      #1;
      chk("full_wr_ready", {31'd0, wr_ready_o}, 32'd0);
      chk("full_fill", {28'd0, fill_o}, 32'd8);
      cyc();
    end
    wr_valid_i = 1'b0;
    drain(60);
    chk("drain_pops", pops, 32'd8);
    #1;
    chk("drain_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("drain_fill", {28'd0, fill_o}, 32'd0);
    cyc();

    // Contention: half full, then continuous write and read over 64 words.
    rd_ready_i = 1'b0;
    pops = 0;
    for (int i = 0; i < 4; i++) push_word(24'h200000 + 24'(i), 2'(i));
    rd_ready_i = 1'b1;
    wr_valid_i = 1'b1; wr_data_i = 24'h5A0000; wr_ch_i = 2'd0;
    k = 0; miss = 0; viol = 0;
    for (int c = 0; c < 400 && k < 64; c++) begin
      #1;
      fullnow = (fill_o == 4'd8);
      cyc();
      if (last_acc) begin
        k++;
        miss = 0;
        wr_data_i = 24'h5A0000 + 24'(k);
        wr_ch_i   = 2'(k);
      end else if (!fullnow) begin
        miss++;
        if (miss >= 2) viol++;
      end
    end
    wr_valid_i = 1'b0;
    chk("cont_written", k, 32'd64);
    chk("cont_wr_starve", viol, 32'd0);
    drain(100);
    chk("cont_pops", pops, 32'd68);

    // Backpressure: random read stalls while writing 20 words.
    pops = 0; k = 0;
    wr_valid_i = 1'b1; wr_data_i = 24'h3C0000; wr_ch_i = 2'd1;
    for (int c = 0; c < 400 && k < 20; c++) begin
      rd_ready_i = 1'($urandom_range(0, 1));
      step();
      if (last_acc) begin
        k++;
        wr_data_i = 24'h3C0000 + 24'(k * 3);
        wr_ch_i   = 2'(k + 1);
      end
    end
    wr_valid_i = 1'b0;
    chk("bp_written", k, 32'd20);
    drain(100);
    chk("bp_pops", pops, 32'd20);

    // Flush with 5 stored words and a fetch in flight.
    rd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push_word(24'h700000 + 24'(i), 2'(i));
    repeat (4) step();
    #1;
    chk("pre_flush_fill", {28'd0, fill_o}, 32'd5);
    chk("pre_flush_rd_valid", {31'd0, rd_valid_o}, 32'd1);
    cyc();
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
    clr_i = 1'b1;
    #1;
    chk("flush_wr_ready", {31'd0, wr_ready_o}, 32'd0);
    cyc();
    clr_i = 1'b0;
    #1;
    chk("post_flush_fill", {28'd0, fill_o}, 32'd0);
    chk("post_flush_rd_valid", {31'd0, rd_valid_o}, 32'd0);
    chk("post_flush_wr_ready", {31'd0, wr_ready_o}, 32'd1);
    cyc();
    pops = 0;
    rd_ready_i = 1'b1;
    push_word(24'h000011, 2'd1);
    drain(20);
    repeat (4) step();
    chk("flush_new_pops", pops, 32'd1);
    #1;
    chk("flush_end_fill", {28'd0, fill_o}, 32'd0);
    cyc();

`ifdef AFE_RINGBUF_WATERMARK_EN
    // Watermark: crossing to 4 pulses once; drop to 3 and refill pulses again.
    thr_i = 4'd4; wm_cnt = 0; rd_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_word(24'h900000 + 24'(i), 2'(i));
    repeat (3) step();
    chk("wm_first", wm_cnt, 32'd1);
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
    repeat (3) step();
    #1;
    chk("wm_fill3", {28'd0, fill_o}, 32'd3);
    cyc();
    push_word(24'h900004, 2'd0);
    repeat (3) step();
    chk("wm_second", wm_cnt, 32'd2);
    thr_i = '0;
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
